// File: rtl/pc_pkg.sv
// pc_pkg: shared PC widths, reset value, source indices and next-PC select encoding.
package pc_pkg;
  localparam int PC_W = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int SRC_TRAP = 0;
  localparam int SRC_JUMP = 1;
  localparam int SRC_BRANCH = 2;
  localparam int SRC_SPARE = 3;
  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_SRC,
    SEL_PEND,
    SEL_HOLD
  } pc_sel_e;
endpackage

// File: rtl/pc_prio_enc.sv
// pc_prio_enc: fixed-priority encoder, lowest set index wins; any flags a request.
module pc_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vld,
  output logic [$clog2(N)-1:0] win,
  output logic                 any
);
  localparam int IW = $clog2(N);
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vld[i]) win = IW'(i);
  end
  assign any = |vld;
endmodule

// File: rtl/pc_next_sel.sv
// pc_next_sel: registered PC with prioritised redirects, stall hold and a one-deep redirect buffer.
// Define PC_ALIGN_CHECK_EN to add the misalign output and force word-aligned targets.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                WIDTH    = PC_W,
  parameter int                NSRC     = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(PC_RESET),
  parameter int                INC      = PC_INC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NSRC-1:0]         src_vld,
  input  logic [NSRC*WIDTH-1:0]   src_addr,
  output logic [WIDTH-1:0]        pc,
  output logic                    redirect,
  output logic [$clog2(NSRC)-1:0] src_idx,
  output logic                    pend
`ifdef PC_ALIGN_CHECK_EN
  , output logic                  misalign
`endif
);
  localparam int IW = $clog2(NSRC);
  logic [IW-1:0]    win, pend_idx, tgt_idx;
  logic             any;
  logic [WIDTH-1:0] win_addr, pend_addr, target, load_addr;
  pc_sel_e          sel;
  pc_prio_enc #(.N(NSRC)) u_enc (
    .vld(src_vld),
    .win(win),
    .any(any)
  );
  assign win_addr = src_addr[int'(win)*WIDTH +: WIDTH];
  always_comb begin
    sel     = stall ? SEL_HOLD : pend ? SEL_PEND : any ? SEL_SRC : SEL_SEQ;
    target  = (sel == SEL_PEND) ? pend_addr : win_addr;
    tgt_idx = (sel == SEL_PEND) ? pend_idx : win;
  end
`ifdef PC_ALIGN_CHECK_EN
  assign load_addr = {target[WIDTH-1:2], 2'b00};
`else
  assign load_addr = target;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      redirect  <= 1'b0;
      src_idx   <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_idx  <= '0;
    end else begin
      redirect <= (sel == SEL_SRC) || (sel == SEL_PEND);
      if (sel == SEL_HOLD) begin
        // Oldest redirect wins: only capture into an empty buffer.
        if (!pend && any) begin
          pend      <= 1'b1;
          pend_addr <= win_addr;
          pend_idx  <= win;
        end
      end else if (sel == SEL_SEQ) begin
        pc <= pc + WIDTH'(INC);
      end else begin
        pc      <= load_addr;
        src_idx <= tgt_idx;
        pend    <= 1'b0;
      end
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) misalign <= 1'b0;
    else misalign <= (sel == SEL_SRC || sel == SEL_PEND) && (|target[1:0]);
  end
`endif
endmodule

// File: tb/tb_pc_next_sel.sv
// tb_pc_next_sel: directed spec scenarios plus randomized traffic against a behavioural model.
module tb_pc_next_sel;
  logic        clk = 0, reset = 1, stall = 0;
  logic [3:0]  src_vld = '0;
  logic [31:0] a [4];
  logic [127:0] src_addr;
  logic [31:0] pc;
  logic        redirect, pend;
  logic [1:0]  src_idx;
  logic        misalign;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_pc, m_paddr;
  bit          m_redir, m_pend, m_mis;
  int          m_idx, m_pidx;

  always #5 clk = ~clk;
  assign src_addr = {a[3], a[2], a[1], a[0]};

  pc_next_sel #(.WIDTH(32), .NSRC(4), .RESET_PC(32'h100), .INC(4)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .src_vld(src_vld),
    .src_addr(src_addr),
    .pc(pc),
    .redirect(redirect),
    .src_idx(src_idx),
    .pend(pend)
`ifdef PC_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );
`ifndef PC_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] t, input int idx);
    m_mis = 0;
`ifdef PC_ALIGN_CHECK_EN
    if (t % 4 != 0) begin
      m_mis = 1;
      t = t - t % 4;
    end
`endif
    m_pc = t;
    m_idx = idx;
    m_redir = 1;
  endtask

  task automatic model();
    int first = -1;
    if (reset) begin
      m_pc = 32'h100; m_redir = 0; m_idx = 0; m_pend = 0; m_paddr = 0; m_pidx = 0; m_mis = 0;
      return;
    end
    for (int i = 0; i < 4; i++) if (src_vld[i] && first < 0) first = i;
    m_mis = 0;
    if (stall) begin
      m_redir = 0;
      if (!m_pend && first >= 0) begin
        m_pend = 1; m_paddr = a[first]; m_pidx = first;
      end
    end else if (m_pend) begin
      load(m_paddr, m_pidx);
      m_pend = 0;
    end else if (first >= 0) begin
      load(a[first], first);
    end else begin
      m_pc = m_pc + 4;
      m_redir = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [3:0] v);
    reset = r; stall = s; src_vld = v;
    @(posedge clk);
    model();
    #1;
    chk("pc", pc, m_pc);
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("src_idx", 32'(src_idx), 32'(m_idx));
    chk("pend", 32'(pend), 32'(m_pend));
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign", 32'(misalign), 32'(m_mis));
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) a[i] = 32'h0;
    step(1, 0, 4'b0000);
    chk("t1_reset_pc", pc, 32'h100);
    step(0, 0, 4'b0000); chk("t1_pc1", pc, 32'h104);
    step(0, 0, 4'b0000); chk("t1_pc2", pc, 32'h108);
    step(0, 0, 4'b0000); chk("t1_pc3", pc, 32'h10C);
    a[1] = 32'h400; a[2] = 32'h800;
    step(0, 0, 4'b0110);
    chk("t2_pc", pc, 32'h400); chk("t2_idx", 32'(src_idx), 1); chk("t2_redir", 32'(redirect), 1);
    step(0, 0, 4'b0000);
    chk("t2_seq", pc, 32'h404); chk("t2_redir0", 32'(redirect), 0);
    a[0] = 32'h40;
    step(0, 1, 4'b0100); chk("t3_hold", pc, 32'h404); chk("t3_pend", 32'(pend), 1);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0000); chk("t3_hold2", pc, 32'h404);
    step(0, 0, 4'b0000);
    chk("t3_pc", pc, 32'h800); chk("t3_idx", 32'(src_idx), 2); chk("t3_pend0", 32'(pend), 0);
    step(0, 0, 4'b0000); chk("t3_drop", pc, 32'h804);
    a[3] = 32'hFFFF_FFFC;
    step(0, 0, 4'b1000); chk("t4_top", pc, 32'hFFFF_FFFC);
    step(0, 0, 4'b0000); chk("t4_wrap", pc, 32'h0);
    step(0, 1, 4'b0010); chk("t5_pend", 32'(pend), 1);
    step(1, 1, 4'b0010);
    chk("t5_pc", pc, 32'h100); chk("t5_pend0", 32'(pend), 0); chk("t5_redir", 32'(redirect), 0);
    step(0, 0, 4'b0000); chk("t5_nostale", pc, 32'h104); chk("t5_redir0", 32'(redirect), 0);
    a[1] = 32'h402;
    step(0, 0, 4'b0010);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_pc", pc, 32'h400); chk("t6_mis", 32'(misalign), 1);
    step(0, 0, 4'b0000); chk("t6_mis0", 32'(misalign), 0);
`else
    chk("t6_pc", pc, 32'h402);
`endif
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        a[i] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
           ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'b0000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
